// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input, decode handshake
// and fault reporting. "master" is the fetch unit side; "slave" is the
// memory/decode/control side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Address;
  logic [INST_WIDTH-1:0] InstructionIn;
  logic                  Redirect;
  logic [ADDR_WIDTH-1:0] RedirectTarget;
  logic                  InstValid;
  logic                  InstReady;
  logic [INST_WIDTH-1:0] InstOut;
  logic [ADDR_WIDTH-1:0] InstPC;
  logic                  Fault;
  logic [ADDR_WIDTH-1:0] FaultPC;

  modport master (
    output Address, InstValid, InstOut, InstPC, Fault, FaultPC,
    input  InstructionIn, Redirect, RedirectTarget, InstReady
  );

  modport slave (
    input  Address, InstValid, InstOut, InstPC, Fault, FaultPC,
    output InstructionIn, Redirect, RedirectTarget, InstReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, reads the combinational
// instruction memory, buffers {PC, instruction} in a small FIFO for decode,
// handles redirects with flush and raises a sticky fault on bad fetch PCs.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           MEM_BYTES   = 1024,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input logic          Clk,
  input logic          Reset,
  fetch_unit_if.master bus
);
  localparam int unsigned           PTR_W   = $clog2(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_BYTES - 4);
  localparam logic [PTR_W:0]        DEPTH   = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0] fault_pc, fault_pc_nxt;
  logic                  fault, fault_nxt;

  logic [INST_WIDTH-1:0] q_inst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W:0]        count;

  logic q_valid, pop, push, flush;
  logic pc_in_range, target_legal;

  assign q_valid      = (count != '0);
  assign pop          = q_valid && bus.InstReady;
  assign pc_in_range  = (fetch_pc <= LAST_PC);
  assign target_legal = (bus.RedirectTarget[1:0] == 2'b00) && (bus.RedirectTarget <= LAST_PC);

  assign bus.Address   = fetch_pc;
  assign bus.InstValid = q_valid;
  assign bus.InstOut   = q_inst[head];
  assign bus.InstPC    = q_pc[head];
  assign bus.Fault     = fault;
  assign bus.FaultPC   = fault_pc;

  // State register for the RUN/FAULT machine.
  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state, next fetch PC, fault update and push/flush decisions.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;
    push         = 1'b0;
    flush        = 1'b0;
    if (bus.Redirect) begin
      flush        = 1'b1;
      fetch_pc_nxt = bus.RedirectTarget;
      if (target_legal) begin
        state_nxt = RUN;
        fault_nxt = 1'b0;
      end else begin
        state_nxt    = FAULT;
        fault_nxt    = 1'b1;
        fault_pc_nxt = bus.RedirectTarget;
      end
    end else begin
      case (state)
        RUN: begin
          if (!pc_in_range) begin
            state_nxt    = FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = fetch_pc;
          end else if ((count < DEPTH) || pop) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch PC and sticky fault registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  // Fetch queue; a flush discards everything, including any same-cycle pop,
  // which the consumer has already taken from the head.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_inst[tail] <= bus.InstructionIn;
        q_pc[tail]   <= fetch_pc;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: combinational memory model, expected {PC, inst}
// scoreboard queues, one task per scenario. Two instances: RESET_PC=0 and
// RESET_PC=MEM_BYTES-8 for the end-of-memory overrun case.
module tb_fetch_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;
  ent_t exp_a[$];
  ent_t exp_b[$];
  ent_t want;

  fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus_a ();
  fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus_b ();

  fetch_unit #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'd0),
    .MEM_BYTES(1024), .QUEUE_DEPTH(2)
  ) dut_a (
    .Clk(clk), .Reset(rst_a), .bus(bus_a.master)
  );

  fetch_unit #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'd1016),
    .MEM_BYTES(1024), .QUEUE_DEPTH(2)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .bus(bus_b.master)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0050_0093;
      32'd4:   return 32'h00A0_0113;
      32'd8:   return 32'h0020_81B3;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb bus_a.InstructionIn = word_at(bus_a.Address);
  always_comb bus_b.InstructionIn = word_at(bus_b.Address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] pc);
    exp_a.push_back({pc, word_at(pc)});
  endtask

  task automatic push_b(input logic [31:0] pc);
    exp_b.push_back({pc, word_at(pc)});
  endtask

  // Two reset edges, then release; returns with Reset low for the next edge.
  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.Redirect = 1'b0;
    bus_a.RedirectTarget = '0;
    bus_a.InstReady = 1'b0;
    exp_a.delete();
    step();
    step();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a();
    checks++; if (bus_a.InstValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.InstValid); end
    checks++; if (bus_a.Address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_a.Address); end
    checks++; if (bus_a.Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus_a.Fault); end
    checks++; if (bus_a.FaultPC !== 32'd0) begin errors++; $display("FAIL reset_faultpc: got %h want 0", bus_a.FaultPC); end
    checks++; if (bus_a.InstOut !== 32'd0) begin errors++; $display("FAIL reset_instout: got %h want 0", bus_a.InstOut); end
    checks++; if (bus_a.InstPC !== 32'd0) begin errors++; $display("FAIL reset_instpc: got %h want 0", bus_a.InstPC); end
  endtask

  task automatic test_basic();
    reset_a();
    push_a(32'd0); push_a(32'd4); push_a(32'd8);
    bus_a.InstReady = 1'b1;
    step();
    checks++; if (bus_a.InstValid !== 1'b1 || bus_a.InstPC !== 32'd0) begin
      errors++; $display("FAIL basic_latency: got valid=%b pc=%h want valid=1 pc=0", bus_a.InstValid, bus_a.InstPC);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_a.InstValid !== 1'b1) begin errors++; $display("FAIL basic_gap: cycle %0d valid=%b want 1", i, bus_a.InstValid); end
      if (bus_a.InstValid && bus_a.InstReady) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL basic_pop: unexpected pc=%h", bus_a.InstPC); end
        else begin
          want = exp_a.pop_front();
          if ({bus_a.InstPC, bus_a.InstOut} !== want) begin
            errors++; $display("FAIL basic_pop: got pc=%h inst=%h want pc=%h inst=%h", bus_a.InstPC, bus_a.InstOut, want.pc, want.inst);
          end
        end
      end
      step();
    end
    bus_a.InstReady = 1'b0;
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL basic_drain: %0d left want 0", exp_a.size()); end
  endtask

  task automatic test_stall();
    reset_a();
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus_a.Address !== 32'd8) begin errors++; $display("FAIL stall_addr: got %h want 8", bus_a.Address); end
    checks++; if (bus_a.InstValid !== 1'b1 || bus_a.InstPC !== 32'd0) begin
      errors++; $display("FAIL stall_head: got valid=%b pc=%h want valid=1 pc=0", bus_a.InstValid, bus_a.InstPC);
    end
    push_a(32'd0); push_a(32'd4); push_a(32'd8);
    bus_a.InstReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_a.InstValid !== 1'b1) begin errors++; $display("FAIL stall_gap: cycle %0d valid=%b want 1", i, bus_a.InstValid); end
      if (bus_a.InstValid && bus_a.InstReady) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL stall_pop: unexpected pc=%h", bus_a.InstPC); end
        else begin
          want = exp_a.pop_front();
          if ({bus_a.InstPC, bus_a.InstOut} !== want) begin
            errors++; $display("FAIL stall_pop: got pc=%h inst=%h want pc=%h inst=%h", bus_a.InstPC, bus_a.InstOut, want.pc, want.inst);
          end
        end
      end
      step();
    end
    bus_a.InstReady = 1'b0;
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL stall_drain: %0d left want 0", exp_a.size()); end
  endtask

  task automatic test_redirect_flush();
    reset_a();
    step();
    step();
    push_a(32'd0); push_a(32'd4); push_a(32'h40);
    // Cycle loop: pop PC0 (queue refills to {4,8}), then redirect with a pop of PC4,
    // then the first instruction fetched from the target.
    for (int c = 0; c < 4; c++) begin
      bus_a.InstReady = 1'b1;
      bus_a.Redirect = (c == 1);
      bus_a.RedirectTarget = 32'h40;
      if (c == 1) begin
        checks++; if (bus_a.InstPC !== 32'd4) begin errors++; $display("FAIL redir_head: got pc=%h want 4", bus_a.InstPC); end
      end
      if (c == 2) begin
        checks++; if (bus_a.InstValid !== 1'b0 || bus_a.Address !== 32'h40) begin
          errors++; $display("FAIL redir_flush: got valid=%b addr=%h want valid=0 addr=40", bus_a.InstValid, bus_a.Address);
        end
      end
      if (c == 3) begin
        checks++; if (bus_a.InstValid !== 1'b1 || bus_a.InstPC !== 32'h40) begin
          errors++; $display("FAIL redir_target: got valid=%b pc=%h want valid=1 pc=40", bus_a.InstValid, bus_a.InstPC);
        end
      end
      if (bus_a.InstValid && bus_a.InstReady) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL redir_pop: unexpected pc=%h", bus_a.InstPC); end
        else begin
          want = exp_a.pop_front();
          if ({bus_a.InstPC, bus_a.InstOut} !== want) begin
            errors++; $display("FAIL redir_pop: got pc=%h inst=%h want pc=%h inst=%h", bus_a.InstPC, bus_a.InstOut, want.pc, want.inst);
          end
        end
      end
      step();
    end
    bus_a.Redirect = 1'b0;
    bus_a.InstReady = 1'b0;
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL redir_drain: %0d left want 0", exp_a.size()); end
  endtask

  task automatic test_fault_redirect();
    reset_a();
    step();
    bus_a.Redirect = 1'b1;
    bus_a.RedirectTarget = 32'h42;
    step();
    bus_a.Redirect = 1'b0;
    checks++; if (bus_a.Fault !== 1'b1 || bus_a.FaultPC !== 32'h42) begin
      errors++; $display("FAIL fault_misalign: got fault=%b pc=%h want fault=1 pc=42", bus_a.Fault, bus_a.FaultPC);
    end
    checks++; if (bus_a.InstValid !== 1'b0 || bus_a.Address !== 32'h42) begin
      errors++; $display("FAIL fault_flush: got valid=%b addr=%h want valid=0 addr=42", bus_a.InstValid, bus_a.Address);
    end
    bus_a.InstReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus_a.InstValid !== 1'b0 || bus_a.Fault !== 1'b1) begin
        errors++; $display("FAIL fault_hold: cycle %0d valid=%b fault=%b want valid=0 fault=1", i, bus_a.InstValid, bus_a.Fault);
      end
    end
    bus_a.Redirect = 1'b1;
    bus_a.RedirectTarget = 32'h400;
    step();
    bus_a.Redirect = 1'b0;
    checks++; if (bus_a.Fault !== 1'b1 || bus_a.FaultPC !== 32'h400) begin
      errors++; $display("FAIL fault_range: got fault=%b pc=%h want fault=1 pc=400", bus_a.Fault, bus_a.FaultPC);
    end
    bus_a.Redirect = 1'b1;
    bus_a.RedirectTarget = 32'h10;
    step();
    bus_a.Redirect = 1'b0;
    checks++; if (bus_a.Fault !== 1'b0 || bus_a.Address !== 32'h10 || bus_a.InstValid !== 1'b0) begin
      errors++; $display("FAIL fault_clear: got fault=%b addr=%h valid=%b want fault=0 addr=10 valid=0", bus_a.Fault, bus_a.Address, bus_a.InstValid);
    end
    push_a(32'h10); push_a(32'h14);
    step();
    checks++; if (bus_a.InstValid !== 1'b1 || bus_a.InstPC !== 32'h10) begin
      errors++; $display("FAIL fault_resume: got valid=%b pc=%h want valid=1 pc=10", bus_a.InstValid, bus_a.InstPC);
    end
    for (int i = 0; i < 2; i++) begin
      if (bus_a.InstValid && bus_a.InstReady) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL fault_pop: unexpected pc=%h", bus_a.InstPC); end
        else begin
          want = exp_a.pop_front();
          if ({bus_a.InstPC, bus_a.InstOut} !== want) begin
            errors++; $display("FAIL fault_pop: got pc=%h inst=%h want pc=%h inst=%h", bus_a.InstPC, bus_a.InstOut, want.pc, want.inst);
          end
        end
      end
      step();
    end
    bus_a.InstReady = 1'b0;
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL fault_drain: %0d left want 0", exp_a.size()); end
  endtask

  task automatic test_reset_midstream();
    reset_a();
    step();
    step();
    checks++; if (bus_a.InstValid !== 1'b1 || bus_a.Fault !== 1'b0) begin
      errors++; $display("FAIL mid_full: got valid=%b fault=%b want valid=1 fault=0", bus_a.InstValid, bus_a.Fault);
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++; if (bus_a.InstValid !== 1'b0 || bus_a.Address !== 32'd0 || bus_a.Fault !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got valid=%b addr=%h fault=%b want valid=0 addr=0 fault=0", bus_a.InstValid, bus_a.Address, bus_a.Fault);
    end
    bus_a.Redirect = 1'b1;
    bus_a.RedirectTarget = 32'h42;
    step();
    bus_a.Redirect = 1'b0;
    checks++; if (bus_a.Fault !== 1'b1) begin errors++; $display("FAIL mid_fault_set: got %b want 1", bus_a.Fault); end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++; if (bus_a.Fault !== 1'b0 || bus_a.FaultPC !== 32'd0) begin
      errors++; $display("FAIL mid_fault_clear: got fault=%b pc=%h want fault=0 pc=0", bus_a.Fault, bus_a.FaultPC);
    end
  endtask

  task automatic test_overrun();
    rst_b = 1'b1;
    bus_b.Redirect = 1'b0;
    bus_b.RedirectTarget = '0;
    bus_b.InstReady = 1'b0;
    step();
    step();
    rst_b = 1'b0;
    checks++; if (bus_b.Address !== 32'd1016) begin errors++; $display("FAIL ovr_resetpc: got %0d want 1016", bus_b.Address); end
    step();
    step();
    checks++; if (bus_b.Fault !== 1'b0 || bus_b.Address !== 32'd1024 || bus_b.InstPC !== 32'd1016) begin
      errors++; $display("FAIL ovr_last: got fault=%b addr=%0d pc=%0d want fault=0 addr=1024 pc=1016", bus_b.Fault, bus_b.Address, bus_b.InstPC);
    end
    step();
    checks++; if (bus_b.Fault !== 1'b1 || bus_b.FaultPC !== 32'd1024) begin
      errors++; $display("FAIL ovr_fault: got fault=%b pc=%0d want fault=1 pc=1024", bus_b.Fault, bus_b.FaultPC);
    end
    checks++; if (bus_b.InstValid !== 1'b1) begin errors++; $display("FAIL ovr_noflush: got valid=%b want 1", bus_b.InstValid); end
    push_b(32'd1016); push_b(32'd1020);
    bus_b.InstReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (bus_b.InstValid && bus_b.InstReady) begin
        checks++;
        if (exp_b.size() == 0) begin errors++; $display("FAIL ovr_pop: unexpected pc=%h", bus_b.InstPC); end
        else begin
          want = exp_b.pop_front();
          if ({bus_b.InstPC, bus_b.InstOut} !== want) begin
            errors++; $display("FAIL ovr_pop: got pc=%h inst=%h want pc=%h inst=%h", bus_b.InstPC, bus_b.InstOut, want.pc, want.inst);
          end
        end
      end
      step();
    end
    checks++; if (bus_b.InstValid !== 1'b0 || bus_b.Fault !== 1'b1) begin
      errors++; $display("FAIL ovr_after: got valid=%b fault=%b want valid=0 fault=1", bus_b.InstValid, bus_b.Fault);
    end
    bus_b.InstReady = 1'b0;
    checks++; if (exp_b.size() != 0) begin errors++; $display("FAIL ovr_drain: %0d left want 0", exp_b.size()); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.Redirect = 1'b0;
    bus_a.RedirectTarget = '0;
    bus_a.InstReady = 1'b0;
    bus_b.Redirect = 1'b0;
    bus_b.RedirectTarget = '0;
    bus_b.InstReady = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_flush();
    test_fault_redirect();
    test_reset_midstream();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle CPU, directly upstream of the byte-addressed combinational instruction memory.
- Owns the fetch PC and drives the memory Address port. Captures the returned 32-bit word into a small queue.
- Presents {instruction, PC} to decode with a valid/ready handshake.
- Handles taken-branch/jump redirects with queue flush, and raises a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 0, fetch PC loaded on reset.
- MEM_BYTES, 1024, instruction memory size in bytes; legal fetch PC range is 0..MEM_BYTES-4.
- QUEUE_DEPTH, 2, fetch queue entries; power of two, at least 2.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Address  out  ADDR_WIDTH  to instruction memory; combinationally equal to FetchPC.
- InstructionIn  in  INST_WIDTH  from instruction memory OutputInstruction; valid in the same cycle as Address.
- Redirect  in  1  taken branch/jump this cycle.
- RedirectTarget  in  ADDR_WIDTH  new fetch PC when Redirect=1.
- InstValid  out  1  queue head valid.
- InstReady  in  1  decode accepts the head.
- InstOut  out  INST_WIDTH  queue head instruction.
- InstPC  out  ADDR_WIDTH  queue head PC.
- Fault  out  1  sticky fetch fault.
- FaultPC  out  ADDR_WIDTH  offending address.

Behaviour:
- Reset (synchronous, wins over everything):
  - FetchPC=RESET_PC, queue count=0, state=RUN.
  - InstValid=0, InstOut=0, InstPC=0, Fault=0, FaultPC=0.
- Address=FetchPC at all times, including in FAULT; the memory is read-only, so there is no side effect.
- Pop: occurs when InstValid&&InstReady. InstOut/InstPC come from the head entry, registered in the queue. InstValid = (count!=0).
- Push: occurs in RUN, without Redirect, when FetchPC<=MEM_BYTES-4 and (count<QUEUE_DEPTH or pop this cycle).
  - Writes {FetchPC, InstructionIn}.
  - FetchPC <= FetchPC+4.
- Simultaneous push and pop on a full queue is allowed; count is unchanged.
- Latency: an instruction pushed in cycle N is at the head with InstValid=1 in cycle N+1 when the queue was empty.
- Sustained throughput: 1 instruction/cycle while InstReady=1.
- Stall: InstReady=0 with a full queue means no push and FetchPC holds.
- Redirect (priority over push):
  - A pop handshake in the same cycle completes; the consumer owns that entry.
  - Then all remaining entries are flushed and count=0.
  - No push in the redirect cycle.
  - If RedirectTarget[1:0]==0 and RedirectTarget<=MEM_BYTES-4: FetchPC<=RedirectTarget, state=RUN.
  - Otherwise: state<=FAULT, Fault<=1, FaultPC<=RedirectTarget, FetchPC<=RedirectTarget.
- Sequential overrun: in RUN with FetchPC>MEM_BYTES-4 and no Redirect:
  - state<=FAULT, Fault<=1, FaultPC<=FetchPC, no push.
  - Queued entries are NOT flushed and still drain normally.
- FAULT state:
  - No pushes.
  - Fault stays 1 and FaultPC holds.
  - A legal Redirect returns the state to RUN and clears Fault the next cycle. It flushes as above.
  - An illegal Redirect stays in FAULT and updates FaultPC.
  - Reset clears FAULT.
- FetchPC arithmetic is modulo 2^ADDR_WIDTH. Wrap is unreachable without an earlier overrun fault.
- Reset asserted mid-stream drops all queued entries; InstValid=0 in the cycle after the Reset edge.
- State machine: RUN <-> FAULT only; transitions as above.

Test Plan:
- Reset, memory words at 0/4/8 = 0x00500093/0x00A00113/0x002081B3, InstReady=1 -> InstValid rises 1 cycle after reset release. Outputs (0x00500093,PC 0), (0x00A00113,4), (0x002081B3,8) on consecutive cycles.
- InstReady=0 for 5 cycles from reset -> count saturates at 2 and Address holds at 8. Releasing InstReady delivers PCs 0,4,8 in order with no gaps or duplicates.
- Queue holding PC 4 and 8, Redirect with RedirectTarget=0x40 and a pop in the same cycle -> PC 4 consumed, PC 8 dropped. Next cycle InstValid=0 and Address=0x40; the following cycle InstPC=0x40.
- Redirect with RedirectTarget=0x42 -> Fault=1, FaultPC=0x42, InstValid=0, no further pushes. A subsequent Redirect to 0x10 -> Fault=0 and fetch resumes at 0x10.
- RESET_PC=MEM_BYTES-8 (1016), InstReady=1 -> PCs 1016 and 1020 delivered. Fault=1 with FaultPC=1024, and both queued entries still drain.
- Reset asserted while the queue is full and Fault=0 -> next cycle InstValid=0, Address=RESET_PC, Fault=0.
